us_sched: RTL and testbench

- Frame sequencer for one `us` acquisition channel.
- On each trigger (external, or an internal period timer), issues `sync` once.
- Then, for each enabled sub-channel in ascending order, it loads parameters, waits for the parameter-done flag, fires the sub-sync, and waits for the done flag.
- At frame end it flips the data_buf write half and publishes the completed half for readout.

---
 rtl/us_sched_pkg.sv | 30 +++
 rtl/us_sched_pick.sv | 24 ++
 rtl/us_sched.sv | 178 +++++++++++++++++
 tb/tb_us_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_sched_pkg.sv
// Shared types for the us frame sequencer.
//   state_t    : sequencer FSM states
//   GUARD_CYC  : cycles a wait state ignores its flag after entry
//   lowest_set : index of the lowest set bit of an 8-bit mask (0 if none)
package us_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        LOAD   = 3'd2,
        WAIT_P = 3'd3,
        FIRE   = 3'd4,
        WAIT_D = 3'd5,
        NEXT   = 3'd6,
        FLIP   = 3'd7
    } state_t;

    localparam int GUARD_CYC = 2;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        // Descending scan so the last hit wins, leaving the lowest index.
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/us_sched_pick.sv
// Next-set-bit finder: lowest set bit of mask strictly above idx.
//   mask     : in  8  channel mask
//   idx      : in  3  current index
//   next_idx : out 3  next set index above idx (0 when none)
//   found    : out 1  a set bit above idx exists
module us_sched_pick (
    input  logic [7:0] mask,
    input  logic [2:0] idx,
    output logic [2:0] next_idx,
    output logic       found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (3'(i) > idx)) begin
                next_idx = 3'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/us_sched.sv
// Frame sequencer for one us acquisition channel. Each trigger (external
// pulse or internal period timer) issues one sync, then walks the enabled
// sub-channels in ascending order doing load -> param wait -> sub-sync ->
// done wait, and finally flips the data_buf write half.
//   clk, rst_n        : clock, synchronous active-low reset
//   i_enable          : scheduler enable, low aborts the frame
//   i_int_mode        : 1 = period timer trigger, 0 = i_ext_trig
//   i_ext_trig        : external trigger pulse
//   i_period          : internal trigger period (0 = off)
//   i_ch_mask         : sub-channel enable mask
//   i_timeout         : per-wait limit (0 = infinite)
//   i_clr_err         : clears sticky flags
//   i_param_done/i_done : handshake flags from us
//   o_sync, o_load_param, o_sub_sync, o_sub_channel, o_wr_half : to us
//   o_rd_half         : readable half (~o_wr_half)
//   o_busy, o_frame_done, o_frame_cnt : frame status
//   o_overrun, o_tmo_err : sticky error flags
module us_sched
    import us_sched_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int TMO_W  = 16,
    parameter int PER_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_int_mode,
    input  logic             i_ext_trig,
    input  logic [PER_W-1:0] i_period,
    input  logic [7:0]       i_ch_mask,
    input  logic [TMO_W-1:0] i_timeout,
    input  logic             i_clr_err,
    input  logic             i_param_done,
    input  logic             i_done,
    output logic             o_sync,
    output logic             o_load_param,
    output logic             o_sub_sync,
    output logic [2:0]       o_sub_channel,
    output logic             o_wr_half,
    output logic             o_rd_half,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [15:0]      o_frame_cnt,
    output logic             o_overrun,
    output logic             o_tmo_err
);

    localparam logic [7:0] CH_BITS = 8'((16'd1 << CH_NUM) - 16'd1);

    state_t           state, state_nxt;
    logic [PER_W-1:0] per_cnt;
    logic [TMO_W-1:0] cnt;
    logic [7:0]       mask_lat;
    logic [2:0]       ptr;
    logic             wr_half;
    logic [15:0]      frame_cnt;
    logic             overrun, tmo_err;

    logic [7:0] eff_mask;
    logic       per_run, period_tick, trig;
    logic       wait_st, guard_ok, tmo_hit, progress, tmo_set;
    logic [2:0] pick_idx;
    logic       pick_found;

    assign eff_mask = i_ch_mask & CH_BITS;

    // Period timer: free-runs 0..i_period-1 only while enabled in int mode.
    assign per_run     = i_enable && i_int_mode && (i_period != '0);
    assign period_tick = per_run && (per_cnt == i_period - PER_W'(1));
    assign trig        = i_int_mode ? period_tick : i_ext_trig;

    always_ff @(posedge clk) begin
        if (!rst_n)
            per_cnt <= '0;
        else if (!per_run || (per_cnt >= i_period - PER_W'(1)))
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + PER_W'(1);
    end

    // Wait-state qualifiers. The flag from us still holds its previous value
    // for a couple of cycles after a request, so it is masked by the guard.
    assign wait_st  = (state == WAIT_P) || (state == WAIT_D);
    assign guard_ok = cnt >= TMO_W'(GUARD_CYC);
    assign tmo_hit  = (i_timeout != '0) && (cnt >= i_timeout);
    assign progress = guard_ok && ((state == WAIT_P) ? i_param_done : i_done);
    assign tmo_set  = i_enable && wait_st && tmo_hit && !progress;

    us_sched_pick u_pick (
        .mask     (mask_lat),
        .idx      (ptr),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (trig && (eff_mask != '0)) state_nxt = SYNC;
                SYNC:    state_nxt = LOAD;
                LOAD:    state_nxt = WAIT_P;
                WAIT_P:  if (progress) state_nxt = FIRE;
                         else if (tmo_hit) state_nxt = NEXT;
                FIRE:    state_nxt = WAIT_D;
                WAIT_D:  if (progress || tmo_hit) state_nxt = NEXT;
                NEXT:    state_nxt = pick_found ? LOAD : FLIP;
                FLIP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_sync       = (state == SYNC);
        o_load_param = (state == LOAD);
        o_sub_sync   = (state == FIRE);
        o_frame_done = (state == FLIP) && i_enable;
        o_busy       = (state != IDLE) && (state != FLIP);
    end

    assign o_sub_channel = ptr;
    assign o_wr_half     = wr_half;
    assign o_rd_half     = ~wr_half;
    assign o_frame_cnt   = frame_cnt;
    assign o_overrun     = overrun;
    assign o_tmo_err     = tmo_err;

    // Frame datapath: mask/pointer, wait counter, buffer half, flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_lat  <= '0;
            ptr       <= '0;
            cnt       <= '0;
            wr_half   <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == SYNC) begin
                mask_lat <= eff_mask;
                ptr      <= lowest_set(eff_mask);
            end else if (state == NEXT && state_nxt == LOAD) begin
                ptr <= pick_idx;
            end

            // Zero on any entry to a wait state; saturate so an infinite
            // wait never wraps back into the guard window.
            if (wait_st && state_nxt == state)
                cnt <= (&cnt) ? cnt : cnt + TMO_W'(1);
            else
                cnt <= '0;

            if (state == FLIP && i_enable) begin
                wr_half   <= ~wr_half;
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (trig && state != IDLE) overrun <= 1'b1;
            else if (i_clr_err)        overrun <= 1'b0;

            if (tmo_set)        tmo_err <= 1'b1;
            else if (i_clr_err) tmo_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_us_sched.sv
// Self-checking bench for us_sched. A single-threaded cycle stepper records
// every sync/load/sub-sync/frame-done pulse with its cycle number and emulates
// the us flag behaviour (flag stays stale for two cycles after a request,
// then clears, then rises after a chosen delay). A timeline model computes the
// expected pulse list of a frame straight from the sequencing rules.
module tb_us_sched;

    localparam int CH_NUM = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable, i_int_mode, i_ext_trig, i_clr_err;
    logic [23:0] i_period;
    logic [7:0]  i_ch_mask;
    logic [15:0] i_timeout;
    logic        i_param_done, i_done;
    logic        o_sync, o_load_param, o_sub_sync;
    logic [2:0]  o_sub_channel;
    logic        o_wr_half, o_rd_half, o_busy, o_frame_done;
    logic [15:0] o_frame_cnt;
    logic        o_overrun, o_tmo_err;

    us_sched #(.CH_NUM(CH_NUM), .TMO_W(16), .PER_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_int_mode(i_int_mode),
        .i_ext_trig(i_ext_trig), .i_period(i_period), .i_ch_mask(i_ch_mask),
        .i_timeout(i_timeout), .i_clr_err(i_clr_err), .i_param_done(i_param_done),
        .i_done(i_done), .o_sync(o_sync), .o_load_param(o_load_param),
        .o_sub_sync(o_sub_sync), .o_sub_channel(o_sub_channel), .o_wr_half(o_wr_half),
        .o_rd_half(o_rd_half), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun), .o_tmo_err(o_tmo_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int rq_p[$];
    int rq_d[$];
    int dp[8];
    int dd[8];
    int tmo_m = 0;

    int pd_clr = -1, pd_set = -1, dn_clr = -1, dn_set = -1;
    logic pd_q = 1'b1, dn_q = 1'b1;
    int excl_bad = 0;
    bit busy_seen = 0;
    bit done_seen = 0;
    logic [15:0] frames_exp = '0;
    logic wr_exp = 1'b0;

    function automatic logic [31:0] ev(input int k, input int ch, input int c);
        return {k[3:0], ch[3:0], c[23:0]};
    endfunction

    // Expected pulse timeline of one frame triggered in cycle t.
    function automatic void model_frame(input int t, input logic [7:0] m);
        int c, f, k;
        c = t + 1;
        exp_q.push_back(ev(1, 0, c));
        k = 0;
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch] && ch < CH_NUM) begin
                c = c + 1;
                exp_q.push_back(ev(2, ch, c));
                f = c + dp[k] + 1;
                exp_q.push_back(ev(3, ch, f));
                c = (dd[k] < 0) ? f + 2 + tmo_m : f + dd[k] + 1;
                k++;
            end
        end
        exp_q.push_back(ev(4, 0, c + 1));
    endfunction

    task automatic arm();
        rq_p.delete();
        rq_d.delete();
        for (int k = 0; k < 8; k++) begin
            rq_p.push_back(dp[k]);
            rq_d.push_back(dd[k]);
        end
    endtask

    task automatic tick();
        int d;
        @(negedge clk);
        cyc++;
        if ((o_sync & o_load_param) | (o_sync & o_sub_sync) | (o_load_param & o_sub_sync))
            excl_bad++;
        if (o_busy) busy_seen = 1;
        if (o_sync) got.push_back(ev(1, 0, cyc));
        if (o_load_param) begin
            got.push_back(ev(2, int'(o_sub_channel), cyc));
            d = (rq_p.size() > 0) ? rq_p.pop_front() : 3;
            pd_clr = cyc + 3;
            pd_set = (d < 0) ? -1 : cyc + d;
        end
        if (o_sub_sync) begin
            got.push_back(ev(3, int'(o_sub_channel), cyc));
            d = (rq_d.size() > 0) ? rq_d.pop_front() : 3;
            dn_clr = cyc + 3;
            dn_set = (d < 0) ? -1 : cyc + d;
        end
        if (o_frame_done) begin
            got.push_back(ev(4, 0, cyc));
            done_seen = 1;
        end
        if (cyc == pd_clr) pd_q = 1'b0;
        if (pd_set >= 0 && cyc == pd_set) pd_q = 1'b1;
        if (cyc == dn_clr) dn_q = 1'b0;
        if (dn_set >= 0 && cyc == dn_set) dn_q = 1'b1;
        i_param_done = pd_q;
        i_done = dn_q;
    endtask

    task automatic fire_trig(output int t);
        done_seen = 0;
        i_ext_trig = 1'b1;
        t = cyc;
        tick();
        i_ext_trig = 1'b0;
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        for (int k = 0; k < budget && !done_seen; k++) tick();
        ok = done_seen;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_enable = 1'b0; i_int_mode = 1'b0; i_ext_trig = 1'b0;
        i_clr_err = 1'b0; i_period = '0; i_ch_mask = '0; i_timeout = '0;
        i_param_done = 1'b1; i_done = 1'b1;
        repeat (3) tick();
        checks++; if ({o_sync, o_load_param, o_sub_sync, o_frame_done} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses got %b want 0000", {o_sync, o_load_param, o_sub_sync, o_frame_done}); end
        checks++; if (o_sub_channel !== 3'd0) begin
            errors++; $display("FAIL reset_sub_channel got %0d want 0", o_sub_channel); end
        checks++; if ({o_wr_half, o_rd_half, o_busy} !== 3'b010) begin
            errors++; $display("FAIL reset_half_busy got %b want 010", {o_wr_half, o_rd_half, o_busy}); end
        checks++; if (o_frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_frame_cnt got %0d want 0", o_frame_cnt); end
        checks++; if ({o_overrun, o_tmo_err} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b want 00", {o_overrun, o_tmo_err}); end
        rst_n = 1'b1;
        i_enable = 1'b1;
        tick();
    endtask

    task automatic test_ext_frames();
        logic [7:0] m;
        int t;
        bit ok;
        for (int it = 0; it < 12; it++) begin
            m = (it == 0) ? 8'h05 : 8'($urandom_range(1, 255));
            for (int k = 0; k < 8; k++) begin
                dp[k] = (it == 0) ? 3 : int'($urandom_range(3, 8));
                dd[k] = (it == 0) ? 3 : int'($urandom_range(3, 8));
            end
            tmo_m = (it == 0) ? 0 : int'($urandom_range(0, 1)) * 40;
            i_timeout = 16'(tmo_m);
            arm();
            i_ch_mask = m;
            got.delete(); exp_q.delete(); excl_bad = 0;
            tick();
            fire_trig(t);
            model_frame(t, m);
            tick();
            i_ch_mask = 8'($urandom);
            wait_frame(400, ok);
            frames_exp++; wr_exp = ~wr_exp;
            checks++; if (!ok) begin errors++; $display("FAIL ext_frame_timeout it %0d no frame_done", it); end
            checks++; if (got.size() != exp_q.size()) begin
                errors++; $display("FAIL ext_event_count it %0d got %0d want %0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin
                    errors++; $display("FAIL ext_event it %0d idx %0d got %h want %h", it, i, got[i], exp_q[i]); end
            end
            checks++; if (o_frame_cnt !== frames_exp) begin
                errors++; $display("FAIL ext_frame_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
            checks++; if ({o_wr_half, o_rd_half} !== {wr_exp, ~wr_exp}) begin
                errors++; $display("FAIL ext_halves got %b want %b", {o_wr_half, o_rd_half}, {wr_exp, ~wr_exp}); end
            checks++; if ({o_busy, o_overrun, o_tmo_err} !== 3'b000) begin
                errors++; $display("FAIL ext_status got %b want 000", {o_busy, o_overrun, o_tmo_err}); end
            checks++; if (excl_bad !== 0) begin
                errors++; $display("FAIL ext_pulse_overlap got %0d want 0", excl_bad); end
        end
    endtask

    task automatic test_int_mode();
        int c0;
        for (int k = 0; k < 8; k++) begin dp[k] = 3; dd[k] = 3; end
        tmo_m = 0; i_timeout = '0;
        arm();
        i_ch_mask = 8'h01;
        got.delete(); exp_q.delete(); excl_bad = 0;
        tick();
        i_period = 24'd100;
        i_int_mode = 1'b1;
        c0 = cyc;
        repeat (1000) tick();
        i_int_mode = 1'b0;
        repeat (30) tick();
        // One tick per full period inside the 1000-cycle window.
        for (int k = 0; c0 + 99 + 100 * k <= c0 + 999; k++) begin
            model_frame(c0 + 99 + 100 * k, 8'h01);
            frames_exp++;
        end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL int_event_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL int_event idx %0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (o_frame_cnt !== frames_exp) begin
            errors++; $display("FAIL int_frame_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
        checks++; if (o_overrun !== 1'b0) begin
            errors++; $display("FAIL int_overrun got %b want 0", o_overrun); end
        checks++; if (excl_bad !== 0) begin
            errors++; $display("FAIL int_pulse_overlap got %0d want 0", excl_bad); end
    endtask

    task automatic test_timeout();
        int t;
        bit ok;
        for (int k = 0; k < 8; k++) begin dp[k] = 3; dd[k] = 4; end
        dd[0] = -1;
        tmo_m = 50; i_timeout = 16'd50;
        arm();
        i_ch_mask = 8'h03;
        got.delete(); exp_q.delete();
        tick();
        fire_trig(t);
        model_frame(t, 8'h03);
        wait_frame(400, ok);
        frames_exp++; wr_exp = ~wr_exp;
        checks++; if (!ok) begin errors++; $display("FAIL tmo_frame_timeout no frame_done"); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL tmo_event_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL tmo_event idx %0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (o_tmo_err !== 1'b1) begin
            errors++; $display("FAIL tmo_err_set got %b want 1", o_tmo_err); end
        checks++; if (o_frame_cnt !== frames_exp) begin
            errors++; $display("FAIL tmo_frame_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        tick();
        checks++; if (o_tmo_err !== 1'b0) begin
            errors++; $display("FAIL tmo_err_clear got %b want 0", o_tmo_err); end
        tmo_m = 0; i_timeout = '0;
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        int t;
        bit ok;
        m = 8'($urandom_range(1, 255));
        for (int k = 0; k < 8; k++) begin
            dp[k] = int'($urandom_range(3, 8));
            dd[k] = int'($urandom_range(3, 8));
        end
        arm();
        i_ch_mask = m;
        got.delete(); exp_q.delete();
        tick();
        fire_trig(t);
        model_frame(t, m);
        repeat (4) tick();
        // Second trigger 5 cycles later, with a clear in the same cycle.
        i_ext_trig = 1'b1; i_clr_err = 1'b1;
        tick();
        i_ext_trig = 1'b0; i_clr_err = 1'b0;
        wait_frame(400, ok);
        frames_exp++; wr_exp = ~wr_exp;
        checks++; if (!ok) begin errors++; $display("FAIL ovr_frame_timeout no frame_done"); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL ovr_event_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovr_event idx %0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (o_overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_flag_set got %b want 1", o_overrun); end
        checks++; if (o_frame_cnt !== frames_exp) begin
            errors++; $display("FAIL ovr_frame_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        tick();
        checks++; if (o_overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_flag_clear got %b want 0", o_overrun); end
    endtask

    task automatic test_abort();
        int t;
        bit ok, hit;
        for (int k = 0; k < 8; k++) begin dp[k] = 3; dd[k] = 3; end
        dd[1] = -1;
        arm();
        i_ch_mask = 8'h03;
        got.delete(); exp_q.delete();
        tick();
        fire_trig(t);
        hit = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (o_sub_sync === 1'b1 && o_sub_channel === 3'd1) begin hit = 1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach_ch1 no sub_sync for channel 1"); end
        tick();
        tick();
        i_enable = 1'b0;
        tick();
        checks++; if ({o_busy, o_sync, o_load_param, o_sub_sync, o_frame_done} !== 5'b0) begin
            errors++; $display("FAIL abort_idle got %b want 00000",
                {o_busy, o_sync, o_load_param, o_sub_sync, o_frame_done}); end
        repeat (3) tick();
        checks++; if (o_wr_half !== wr_exp) begin
            errors++; $display("FAIL abort_wr_half got %b want %b", o_wr_half, wr_exp); end
        checks++; if (o_frame_cnt !== frames_exp) begin
            errors++; $display("FAIL abort_frame_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
        i_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin dp[k] = 3; dd[k] = 3; end
        arm();
        got.delete(); exp_q.delete();
        tick();
        fire_trig(t);
        model_frame(t, 8'h03);
        wait_frame(400, ok);
        frames_exp++; wr_exp = ~wr_exp;
        checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout no frame_done"); end
        checks++; if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL abort_event_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_event idx %0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (o_frame_cnt !== frames_exp) begin
            errors++; $display("FAIL abort_restart_cnt got %0d want %0d", o_frame_cnt, frames_exp); end
    endtask

    task automatic test_no_trigger();
        i_ch_mask = 8'h00;
        got.delete();
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            i_ext_trig = 1'b1;
            tick();
            i_ext_trig = 1'b0;
            repeat (5) tick();
        end
        checks++; if (got.size() != 0) begin
            errors++; $display("FAIL mask0_events got %0d want 0", got.size()); end
        checks++; if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL mask0_busy got %b want 0", busy_seen); end
        i_ch_mask = 8'hff;
        i_period = '0;
        i_int_mode = 1'b1;
        repeat (300) tick();
        i_int_mode = 1'b0;
        tick();
        checks++; if (got.size() != 0) begin
            errors++; $display("FAIL period0_events got %0d want 0", got.size()); end
        checks++; if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL period0_busy got %b want 0", busy_seen); end
        checks++; if (o_overrun !== 1'b0) begin
            errors++; $display("FAIL idle_overrun got %b want 0", o_overrun); end
    endtask

    initial begin
        test_reset();
        test_ext_frames();
        test_int_mode();
        test_timeout();
        test_overrun();
        test_abort();
        test_no_trigger();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
